regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the RV32 core and its multi-issue successors.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_clear_fsm.sv | 63 ++++++
 rtl/regfile_mp.sv | 80 ++++++++
 tb/tb_regfile_mp.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int unsigned ZERO_ADDR = 0;

  // Address width for a given depth; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: sweeps every entry to zero, one per cycle,
// then raises ready and stays in RUN until the next reset.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  output logic                       clr_we,
  output logic [addr_w(DEPTH)-1:0]   clr_addr
);

  localparam int unsigned AW = addr_w(DEPTH);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            ready_d;
  logic            clr_we_d;

  // Next-state logic; ready/clr_we are registered decodes of the next state.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ready_d  = 1'b0;
    clr_we_d = 1'b0;
    case (state_q)
      CLEAR: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
        idx_d   = '0;
      end
    endcase
    ready_d  = (state_d == RUN);
    clr_we_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      ready   <= 1'b0;
      clr_we  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready   <= ready_d;
      clr_we  <= clr_we_d;
    end
  end

  assign clr_addr = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with post-reset clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  output logic                                  ready,
  input  logic [NUM_WR-1:0]                     we,
  input  logic [NUM_WR-1:0][addr_w(DEPTH)-1:0]  waddr,
  input  logic [NUM_WR-1:0][XLEN-1:0]           wdata,
  input  logic [NUM_RD-1:0][addr_w(DEPTH)-1:0]  raddr,
  output logic [NUM_RD-1:0][XLEN-1:0]           rdata
);

  localparam int unsigned AW = addr_w(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic [NUM_WR-1:0] wr_ok_c;

  regfile_clear_fsm #(
    .DEPTH (DEPTH)
  ) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A user write is legal only in RUN and never to the hard-wired zero entry.
  always_comb begin
    wr_ok_c = '0;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      wr_ok_c[p] = ready && we[p] &&
                   !((ZERO_REG != 0) && (waddr[p] == AW'(ZERO_ADDR)));
    end
  end

  // Ascending port loop: the last (highest-index) write to an address wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[clr_addr] <= '0;
      end else begin
        for (int unsigned p = 0; p < NUM_WR; p++) begin
          if (wr_ok_c[p]) begin
            mem[waddr[p]] <= wdata[p];
          end
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      rdata[r] = mem[raddr[r]];
`ifdef REGFILE_BYPASS_EN
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (wr_ok_c[p] && (waddr[p] == raddr[r])) begin
          rdata[r] = wdata[p];
        end
      end
`endif
      if (!ready || ((ZERO_REG != 0) && (raddr[r] == AW'(ZERO_ADDR)))) begin
        rdata[r] = '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a 2W/2R zero-reg instance and a 1W/1R plain instance.
module tb_regfile_mp;

  localparam int unsigned AW = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  typedef struct {
    int          src;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  ready;
  logic [1:0]            we;
  logic [1:0][AW-1:0]    waddr;
  logic [1:0][31:0]      wdata;
  logic [1:0][AW-1:0]    raddr;
  logic [1:0][31:0]      rdata;

  logic                  ready_z;
  logic [0:0]            we_z;
  logic [0:0][AW-1:0]    waddr_z;
  logic [0:0][31:0]      wdata_z;
  logic [0:0][AW-1:0]    raddr_z;
  logic [0:0][31:0]      rdata_z;

  chk_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  regfile_mp #(
    .XLEN(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata)
  );

  regfile_mp #(
    .XLEN(32), .DEPTH(32), .NUM_RD(1), .NUM_WR(1), .ZERO_REG(0)
  ) dut_z (
    .clk(clk), .rst(rst), .ready(ready_z), .we(we_z), .waddr(waddr_z),
    .wdata(wdata_z), .raddr(raddr_z), .rdata(rdata_z)
  );

  function automatic logic [31:0] obs(input int src);
    case (src)
      0:       return rdata[0];
      1:       return rdata[1];
      2:       return rdata_z[0];
      3:       return 32'(ready);
      4:       return 32'(ready_z);
      default: return 'x;
    endcase
  endfunction

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge clk) begin
    chk_t c;
    logic [31:0] got;
    while (q.size() != 0) begin
      c   = q.pop_front();
      got = obs(c.src);
      n_tests++;
      if (got !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", c.name, got, c.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int src, input logic [31:0] v, input string name);
    q.push_back('{src: src, exp: v, name: name});
  endtask

  task automatic idle();
    we   = '0;
    we_z = '0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
    we[p]    = 1'b1;
    waddr[p] = a;
    wdata[p] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    waddr = '0; wdata = '0; raddr = '0;
    waddr_z = '0; wdata_z = '0; raddr_z = '0;
    step();
    step();
    rst = 1'b0;

    // Clear sweep: ready low for 32 cycles, reads forced to 0 meanwhile.
    for (int i = 0; i < 32; i++) begin
      raddr[0] = AW'(i);
      expect_v(3, 32'h0, "clear_ready_lo");
      expect_v(4, 32'h0, "clear_ready_lo_z");
      expect_v(0, 32'h0, "clear_rdata_zero");
      step();
    end
    expect_v(3, 32'h1, "clear_ready_hi");
    expect_v(4, 32'h1, "clear_ready_hi_z");
    step();

    for (int a = 0; a < 32; a++) begin
      raddr[0]   = AW'(a);
      raddr[1]   = AW'(31 - a);
      raddr_z[0] = AW'(a);
      expect_v(0, 32'h0, $sformatf("sweep_rd0 x%0d", a));
      expect_v(1, 32'h0, $sformatf("sweep_rd1 x%0d", 31 - a));
      expect_v(2, 32'h0, $sformatf("sweep_rdz x%0d", a));
      step();
    end

    // Basic write then read on both ports.
    wr(0, 5'd5, 32'hDEADBEEF);
    step();
    idle();
    raddr[0] = 5'd5; raddr[1] = 5'd5;
    expect_v(0, 32'hDEADBEEF, "basic_rd0");
    expect_v(1, 32'hDEADBEEF, "basic_rd1");
    step();

    // Zero register versus ordinary entry 0.
    wr(0, 5'd0, 32'hFFFFFFFF);
    we_z = 1'b1; waddr_z[0] = 5'd0; wdata_z[0] = 32'hFFFFFFFF;
    raddr[1] = 5'd0; raddr_z[0] = 5'd0;
    expect_v(1, 32'h0, "zero_same_cycle");
    expect_v(2, BP ? 32'hFFFFFFFF : 32'h0, "x0_plain_same_cycle");
    step();
    idle();
    raddr[0] = 5'd0;
    expect_v(0, 32'h0, "zero_reg_rd");
    expect_v(2, 32'hFFFFFFFF, "x0_plain_rd");
    step();

    // Port conflict: highest index wins.
    wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22);
    raddr[0] = 5'd7;
    expect_v(0, BP ? 32'h22 : 32'h0, "conflict_same_cycle");
    step();
    idle();
    raddr[0] = 5'd7; raddr[1] = 5'd7;
    expect_v(0, 32'h22, "conflict_rd0");
    expect_v(1, 32'h22, "conflict_rd1");
    step();
    wr(0, 5'd8, 32'h33); wr(1, 5'd10, 32'h44);
    step();
    idle();
    raddr[0] = 5'd8; raddr[1] = 5'd10;
    expect_v(0, 32'h33, "dual_wr_p0");
    expect_v(1, 32'h44, "dual_wr_p1");
    step();

    // Same-cycle read/write of x9.
    wr(0, 5'd9, 32'hA);
    step();
    idle();
    wr(0, 5'd9, 32'hB);
    raddr[0] = 5'd9; raddr[1] = 5'd9;
    expect_v(0, BP ? 32'hB : 32'hA, "rw_same_cycle_rd0");
    expect_v(1, BP ? 32'hB : 32'hA, "rw_same_cycle_rd1");
    step();
    idle();
    expect_v(0, 32'hB, "rw_next_cycle");
    step();
    wr(0, 5'd9, 32'hC); wr(1, 5'd9, 32'hD);
    expect_v(1, BP ? 32'hD : 32'hB, "bypass_conflict");
    step();
    idle();
    expect_v(1, 32'hD, "bypass_conflict_next");
    step();

    // Reset mid-sweep, writes held during CLEAR are ignored.
    wr(0, 5'd3, 32'h99); wr(1, 5'd20, 32'h20);
    step();
    idle();
    raddr[0] = 5'd3; raddr[1] = 5'd20;
    expect_v(0, 32'h99, "pre_rst_x3");
    expect_v(1, 32'h20, "pre_rst_x20");
    step();
    rst = 1'b1;
    wr(0, 5'd3, 32'h77);
    step();
    rst = 1'b0;
    wr(0, 5'd3, 32'h55);
    for (int i = 0; i < 10; i++) begin
      expect_v(3, 32'h0, "sweep1_ready_lo");
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      expect_v(3, 32'h0, "sweep2_ready_lo");
      step();
    end
    idle();
    expect_v(3, 32'h1, "sweep2_ready_hi");
    expect_v(0, 32'h0, "post_sweep_x3");
    expect_v(1, 32'h0, "post_sweep_x20");
    step();

    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks left unprocessed, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
